sram_axi_bridge: RTL

Converts the core's two SRAM-like request channels (instruction fetch, data access) into one single-beat AXI master port with a fixed 32-bit data path. It replaces the direct `inst_sram`/`data_sram` connections at the CPU top level. Each channel gets parametrised read outstanding depth, ID-tagged response routing, fixed data-over-inst arbitration and a one-deep write path.

---
 rtl/sram_axi_bridge_if.sv | 46 ++++
 rtl/sram_axi_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI read/write channel bundle between the SRAM-like bridge and the AXI wrapper.
// Burst, cache, lock, prot and write IDs are tied off in the wrapper, so they are absent here.
interface sram_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;

  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arsize, arvalid, input arready,
    input rid, rdata, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bvalid, output bready
  );

  modport slave (
    input arid, araddr, arsize, arvalid, output arready,
    output rid, rdata, rvalid, input rready,
    input awaddr, awsize, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the instruction-fetch and data SRAM-like channels onto one single-beat AXI master.
// Reads share one AR slot (data wins); data writes use a one-deep AW/W/B path.
module sram_axi_bridge #(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2,
  parameter int ID_W    = 4
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,

  sram_axi_bridge_if.master axi
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUT);
  localparam logic [ID_W-1:0] ID_INST = '0;
  localparam logic [ID_W-1:0] ID_DATA = ID_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAIT_B} wstate_t;

  wstate_t           wstate;
  logic [CW-1:0]     icnt, dcnt;

  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [2:0]        ar_size;

  logic              aw_valid, w_valid, b_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_size;
  logic [31:0]       w_data;
  logic [3:0]        w_strb, strb_next;

  logic slot_free, ar_has_data, data_rd_acc, data_wr_acc, inst_acc;
  logic r_inst, r_data, b_done;
  logic unused_inst_wdata;

  assign unused_inst_wdata = ^inst_wdata;

  // The slot refills in the same cycle it drains, allowing one AR per cycle.
  assign slot_free   = ~ar_valid | axi.arready;
  assign ar_has_data = ar_valid & (ar_id == ID_DATA);

  assign data_rd_acc = data_req & ~data_wr & slot_free & (dcnt < MAX_CNT) & (wstate == W_IDLE);
  assign data_wr_acc = data_req & data_wr & (wstate == W_IDLE) & (dcnt == '0) & ~ar_has_data;
  assign inst_acc    = inst_req & ~inst_wr & slot_free & (icnt < MAX_CNT) & ~data_rd_acc;

  assign r_inst = axi.rvalid & (axi.rid == ID_INST);
  assign r_data = axi.rvalid & (axi.rid == ID_DATA);
  assign b_done = (wstate == W_WAIT_B) & axi.bvalid;

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = data_rd_acc | data_wr_acc;
  assign inst_data_ok = r_inst;
  assign inst_rdata   = axi.rdata;
  assign data_data_ok = r_data | b_done;
  assign data_rdata   = axi.rdata;

  assign axi.arvalid = ar_valid;
  assign axi.araddr  = ar_addr;
  assign axi.arid    = ar_id;
  assign axi.arsize  = ar_size;
  assign axi.rready  = 1'b1;
  assign axi.awvalid = aw_valid;
  assign axi.awaddr  = aw_addr;
  assign axi.awsize  = aw_size;
  assign axi.wvalid  = w_valid;
  assign axi.wdata   = w_data;
  assign axi.wstrb   = w_strb;
  assign axi.bready  = b_ready;

  always_comb begin
    strb_next = 4'b1111;
    case (data_size)
      2'd0:    strb_next = 4'b0001 << data_addr[1:0];
      2'd1:    strb_next = data_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_next = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_size  <= '0;
      icnt     <= '0;
      dcnt     <= '0;
    end else begin
      if (data_rd_acc) begin
        ar_valid <= 1'b1;
        ar_addr  <= data_addr;
        ar_id    <= ID_DATA;
        ar_size  <= {1'b0, data_size};
      end else if (inst_acc) begin
        ar_valid <= 1'b1;
        ar_addr  <= inst_addr;
        ar_id    <= ID_INST;
        ar_size  <= {1'b0, inst_size};
      end else if (axi.arready) begin
        ar_valid <= 1'b0;
      end

      if (inst_acc && !r_inst)      icnt <= icnt + 1'b1;
      else if (!inst_acc && r_inst) icnt <= icnt - 1'b1;

      if (data_rd_acc && !r_data)      dcnt <= dcnt + 1'b1;
      else if (!data_rd_acc && r_data) dcnt <= dcnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate   <= W_IDLE;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      b_ready  <= 1'b0;
      aw_addr  <= '0;
      aw_size  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (data_wr_acc) begin
          aw_addr  <= data_addr;
          aw_size  <= {1'b0, data_size};
          w_data   <= data_wdata;
          w_strb   <= strb_next;
          aw_valid <= 1'b1;
          w_valid  <= 1'b1;
          wstate   <= W_SEND;
        end
        W_SEND: begin
          if (axi.awready) aw_valid <= 1'b0;
          if (axi.wready)  w_valid  <= 1'b0;
          if ((!aw_valid || axi.awready) && (!w_valid || axi.wready)) begin
            b_ready <= 1'b1;
            wstate  <= W_WAIT_B;
          end
        end
        W_WAIT_B: if (axi.bvalid) begin
          b_ready <= 1'b0;
          wstate  <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  a_inst_no_underflow: assert property (@(posedge clk) disable iff (!resetn) r_inst |-> (icnt != '0));
  a_data_no_underflow: assert property (@(posedge clk) disable iff (!resetn) r_data |-> (dcnt != '0));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn) (icnt <= MAX_CNT) && (dcnt <= MAX_CNT));

endmodule
